// File: rtl/mod_n_pkg.sv
// Shared types and helpers for the dual-rail mod-N residue receivers.
// Holds the FSM state enum, pair encodings and the residue step function.
package mod_n_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_SP,
    ERR
  } state_t;

  // Pair encoding, read as {true_rail, false_rail}.
  localparam logic [1:0] PAIR_NULL    = 2'b00;
  localparam logic [1:0] PAIR_VALID0  = 2'b01;
  localparam logic [1:0] PAIR_VALID1  = 2'b10;
  localparam logic [1:0] PAIR_ILLEGAL = 2'b11;

  // Widest legal case: 8-bit residue (N <= 255) plus a 4-bit digit.
  function automatic logic [7:0] res_next(
    input logic [7:0] res,
    input logic [3:0] d,
    input int         dw,
    input logic [7:0] modulus
  );
    logic [11:0] acc;
    acc = (12'(res) << dw) | 12'(d);
    return 8'(acc % 12'(modulus));
  endfunction

endpackage

// File: rtl/dr_sync_detect.sv
// Synchroniser plus complete/spacer/illegal detector for a dual-rail bus.
// Ports: clk, rst, in0/in1 (false/true rails), data, complete, spacer, illegal.
module dr_sync_detect
  import mod_n_pkg::*;
#(
  parameter int DIGIT_W     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] in0,
  input  logic [DIGIT_W-1:0] in1,
  output logic [DIGIT_W-1:0] data,
  output logic               complete,
  output logic               spacer,
  output logic               illegal
);

  logic [2*DIGIT_W-1:0] sync_q [SYNC_STAGES];
  logic [DIGIT_W-1:0]   s0;
  logic [DIGIT_W-1:0]   s1;
  logic [1:0]           pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {in1, in0};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s0   = sync_q[SYNC_STAGES-1][DIGIT_W-1:0];
  assign s1   = sync_q[SYNC_STAGES-1][2*DIGIT_W-1:DIGIT_W];
  assign data = s1;

  always_comb begin
    complete = 1'b1;
    spacer   = 1'b1;
    illegal  = 1'b0;
    pair     = PAIR_NULL;
    for (int i = 0; i < DIGIT_W; i++) begin
      pair = {s1[i], s0[i]};
      unique case (pair)
        PAIR_NULL: complete = 1'b0;
        PAIR_VALID0,
        PAIR_VALID1: spacer = 1'b0;
        PAIR_ILLEGAL: begin
          complete = 1'b0;
          spacer   = 1'b0;
          illegal  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mod_n_residue_dr.sv
// Serial MSB-first dual-rail digit stream -> running residue mod MODULUS.
// Ports: clk, rst, in0/in1 digit rails, out0/out1 result rails, residue,
// busy; code_err only when MOD_N_CODE_ERR_EN is defined.
module mod_n_residue_dr
  import mod_n_pkg::*;
#(
  parameter int MODULUS     = 3,
  parameter int DIGIT_W     = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RES_W       = $clog2(MODULUS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] in0,
  input  logic [DIGIT_W-1:0] in1,
  output logic               out0,
  output logic               out1,
  output logic [RES_W-1:0]   residue,
  output logic               busy
`ifdef MOD_N_CODE_ERR_EN
  ,
  output logic               code_err
`endif
);

  logic [DIGIT_W-1:0] data;
  logic               complete;
  logic               spacer;
  logic               illegal;
  logic               err_hit;
  logic [RES_W-1:0]   res_nx;

  state_t           state_q, state_d;
  logic [RES_W-1:0] residue_q, residue_d;
  logic             out0_q, out0_d;
  logic             out1_q, out1_d;
  logic             busy_q, busy_d;

  dr_sync_detect #(
    .DIGIT_W     (DIGIT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_det (
    .clk      (clk),
    .rst      (rst),
    .in0      (in0),
    .in1      (in1),
    .data     (data),
    .complete (complete),
    .spacer   (spacer),
    .illegal  (illegal)
  );

`ifdef MOD_N_CODE_ERR_EN
  assign err_hit  = illegal;
  assign code_err = (state_q == ERR);
`else
  assign err_hit  = 1'b0;
`endif

  assign res_nx = RES_W'(res_next(8'(residue_q), 4'(data),
                                  DIGIT_W, 8'(MODULUS)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      residue_q <= '0;
      out0_q    <= 1'b0;
      out1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (err_hit) begin
          state_d = ERR;
          out0_d  = 1'b0;
          out1_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (complete && !illegal) begin
          state_d   = ACK;
          residue_d = res_nx;
          out1_d    = (res_nx == '0);
          out0_d    = (res_nx != '0);
          busy_d    = 1'b1;
        end
      end
      ACK: begin
        if (err_hit) begin
          state_d = ERR;
          out0_d  = 1'b0;
          out1_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (spacer) begin
          state_d = WAIT_SP;
        end
      end
      WAIT_SP: begin
        state_d = IDLE;
        out0_d  = 1'b0;
        out1_d  = 1'b0;
        busy_d  = 1'b0;
      end
      ERR: begin
        out0_d = 1'b0;
        out1_d = 1'b0;
        busy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out0    = out0_q;
  assign out1    = out1_q;
  assign residue = residue_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mod_n_residue_dr.sv
// Directed bench: instance A (N=3, 1-bit digits), instance B (N=5, 2-bit).
// Builds with or without MOD_N_CODE_ERR_EN.
module tb_mod_n_residue_dr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_in0, a_in1, a_out0, a_out1, a_busy;
  logic [1:0] a_res;
  logic [1:0] b_in0, b_in1;
  logic       b_out0, b_out1, b_busy;
  logic [2:0] b_res;
`ifdef MOD_N_CODE_ERR_EN
  logic       a_err, b_err;
`endif

  int total  = 0;
  int passed = 0;

  mod_n_residue_dr #(.MODULUS(3), .DIGIT_W(1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .in0     (a_in0),
    .in1     (a_in1),
    .out0    (a_out0),
    .out1    (a_out1),
    .residue (a_res),
    .busy    (a_busy)
`ifdef MOD_N_CODE_ERR_EN
    ,
    .code_err(a_err)
`endif
  );

  mod_n_residue_dr #(.MODULUS(5), .DIGIT_W(2)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .in0     (b_in0),
    .in1     (b_in1),
    .out0    (b_out0),
    .out1    (b_out1),
    .residue (b_res),
    .busy    (b_busy)
`ifdef MOD_N_CODE_ERR_EN
    ,
    .code_err(b_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit which, input logic [1:0] i0,
                       input logic [1:0] i1);
    if (which) begin
      b_in0 = i0;
      b_in1 = i1;
    end else begin
      a_in0 = i0[0];
      a_in1 = i1[0];
    end
  endtask

  function automatic logic [3:0] obs(input bit which);
    return which ? {b_busy, b_out1, b_out0, 1'b0}
                 : {a_busy, a_out1, a_out0, 1'b0};
  endfunction

  function automatic logic [2:0] res_of(input bit which);
    return which ? b_res : {1'b0, a_res};
  endfunction

  task automatic wait_rails(input bit which, input string tag);
    int n = 0;
    while ((obs(which) & 4'b0110) == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tok_in_time"}, 32'(n < 20), 32'd1);
  endtask

  task automatic wait_idle(input bit which, input string tag);
    int n = 0;
    while (obs(which)[3] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, 32'(n < 20), 32'd1);
  endtask

  // Full four-phase handshake for one digit.
  task automatic digit(input bit which, input logic [1:0] d,
                       input int exp_res, input bit exp_z, input string tag);
    drive(which, ~d, d);
    wait_rails(which, tag);
    check({tag, "_rails"}, 32'(obs(which)),
          32'({1'b1, exp_z, ~exp_z, 1'b0}));
    check({tag, "_res"}, 32'(res_of(which)), 32'(exp_res));
    drive(which, 2'b00, 2'b00);
    wait_idle(which, tag);
    check({tag, "_released"}, 32'(obs(which)), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, 2'b00);
    drive(1, 2'b00, 2'b00);
    tick(3);
    check("rst_a_out", 32'(obs(0)), 32'd0);
    check("rst_a_res", 32'(a_res), 32'd0);
    rst = 1'b0;
    tick(5);
    check("idle_a_out", 32'(obs(0)), 32'd0);
    check("idle_a_res", 32'(a_res), 32'd0);
    check("idle_b_out", 32'(obs(1)), 32'd0);
    check("idle_b_res", 32'(b_res), 32'd0);
`ifdef MOD_N_CODE_ERR_EN
    check("idle_a_err", 32'(a_err), 32'd0);
    check("idle_b_err", 32'(b_err), 32'd0);
`endif

    // Value 6 = 110b, mod 3: residues 1, 0, 0.
    digit(0, 2'd1, 1, 1'b0, "a_d1");
    digit(0, 2'd1, 0, 1'b1, "a_d11");
    digit(0, 2'd0, 0, 1'b1, "a_d110");

    // Codeword held long past its token: one update only.
    drive(0, 2'b00, 2'b01);
    wait_rails(0, "hold");
    check("hold_first", 32'(a_res), 32'd1);
    tick(10);
    check("hold_res_once", 32'(a_res), 32'd1);
    check("hold_rails", 32'(obs(0)), 32'b1010);
    drive(0, 2'b00, 2'b00);
    tick(1);
    check("hold_until_sp", 32'(a_out0), 32'd1);
    wait_idle(0, "hold");
    check("hold_released", 32'(obs(0)), 32'd0);
    check("hold_res_after", 32'(a_res), 32'd1);

    // Reset in ACK: residue 1 -> digit 0 -> 2, then abort.
    drive(0, 2'b01, 2'b00);
    wait_rails(0, "rstack");
    check("rstack_pre_res", 32'(a_res), 32'd2);
    check("rstack_pre_out", 32'(obs(0)), 32'b1010);
    #2 rst = 1'b1;
    #1;
    check("rstack_out", 32'(obs(0)), 32'd0);
    check("rstack_res", 32'(a_res), 32'd0);
    drive(0, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // Partial codeword on B: only pair 0 valid.
    drive(1, 2'b01, 2'b00);
    tick(20);
    check("part_wait", 32'(obs(1)), 32'd0);
    check("part_res", 32'(b_res), 32'd0);
    drive(1, 2'b11, 2'b00);
    tick(2);
    check("part_not_yet", 32'(b_busy), 32'd0);
    tick(1);
    check("part_capture", 32'(obs(1)), 32'b1100);
    drive(1, 2'b00, 2'b00);
    wait_idle(1, "part");

    // Digits 2,3,1 mod 5: residues 2, 1, 0.
    digit(1, 2'd2, 2, 1'b0, "b_d2");
    digit(1, 2'd3, 1, 1'b0, "b_d23");
    digit(1, 2'd1, 0, 1'b1, "b_d231");

    // Illegal pair 0 in IDLE, then a legal digit 3.
    drive(1, 2'b01, 2'b01);
    tick(10);
`ifdef MOD_N_CODE_ERR_EN
    check("ill_err", 32'(b_err), 32'd1);
    check("ill_out", 32'(obs(1)), 32'b1000);
    check("ill_res", 32'(b_res), 32'd0);
    drive(1, 2'b00, 2'b11);
    tick(10);
    check("ill_frozen_res", 32'(b_res), 32'd0);
    check("ill_frozen_out", 32'(obs(1)), 32'b1000);
    check("ill_sticky", 32'(b_err), 32'd1);
`else
    check("ill_wait_out", 32'(obs(1)), 32'd0);
    check("ill_wait_res", 32'(b_res), 32'd0);
    drive(1, 2'b00, 2'b11);
    tick(10);
    check("ill_then_res", 32'(b_res), 32'd3);
    check("ill_then_out", 32'(obs(1)), 32'b1010);
`endif
    drive(1, 2'b00, 2'b00);
    tick(6);
    rst = 1'b1;
    #1;
    check("final_rst_b", 32'(obs(1)), 32'd0);
    check("final_rst_res", 32'(b_res), 32'd0);
`ifdef MOD_N_CODE_ERR_EN
    check("final_rst_err", 32'(b_err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mod_n_residue_dr.md
Name: mod_n_residue_dr

Overview:
- Clocked, parametrised successor to the dual-rail multiply-of-three detector.
- Consumes a serial MSB-first number as dual-rail, four-phase return-to-zero digits of DIGIT_W bits each.
- Keeps a running residue modulo MODULUS and answers each digit with a dual-rail "divisible / not divisible" token.
- Sits between an asynchronous dual-rail producer and synchronous logic; includes its own input synchronisers.

Parameters:
- MODULUS, 3, divisor N; legal range 2..255.
- DIGIT_W, 1, bits per digit; each digit is carried on DIGIT_W dual-rail pairs; legal range 1..4.
- SYNC_STAGES, 2, flip-flop stages on every input rail; minimum 2.
- RES_W, $clog2(MODULUS), width of the exported residue.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in0  in  DIGIT_W  false rails; bit i high means digit bit i = 0.
- in1  in  DIGIT_W  true rails; bit i high means digit bit i = 1.
- out0  out  1  result rail: residue != 0 after the current digit.
- out1  out  1  result rail: residue == 0 after the current digit.
- residue  out  RES_W  registered running residue.
- busy  out  1  high from digit capture until the spacer has been seen and the output rails have been released.

Behaviour:
- Reset (asynchronous, active-high): all synchroniser flops 0; state IDLE; residue 0; out0, out1 and busy all 0. Reset asserted mid-handshake aborts the handshake immediately; no token is produced.
- Synchronisation: in0 and in1 each pass through SYNC_STAGES flops. All decisions below use the synchronised view s0/s1.
- Pair states:
  - valid: exactly one of s0[i], s1[i] high.
  - null: both low.
  - illegal: both high.
- Codeword states:
  - complete: all pairs valid.
  - spacer: all pairs null.
  - any other mix is incomplete and is ignored (wait).
- FSM states: IDLE, ACK, WAIT_SP.
  - IDLE: when the codeword is complete at cycle t, capture d = s1, go to ACK.
    - At t+1: residue = (residue * 2^DIGIT_W + d) mod MODULUS. Exactly one of out1/out0 is high: out1 if the new residue is 0, else out0. busy = 1.
    - Arithmetic uses an intermediate of RES_W+DIGIT_W bits; the result is always < MODULUS.
  - ACK: hold the output rail until the codeword becomes spacer, then go to WAIT_SP.
  - WAIT_SP: out0 = out1 = 0 at the following edge. busy drops in the same cycle. Return to IDLE.
    - out0 and out1 are never high simultaneously.
    - A new complete codeword is accepted no earlier than one cycle after the rails are released.
- A producer that re-presents a complete codeword before the spacer is ignored: no double count.
- Illegal pairs without the optional feature: treated as incomplete (wait).
- No wrap concern: the residue is always reduced, so unbounded streams are supported.
- The residue clears only on rst.

Optional Feature:
- Macro: MOD_N_CODE_ERR_EN.
- Defined: adds output port code_err (out, 1). Any illegal pair seen in IDLE or ACK sets code_err at the next edge. The FSM enters ERR: out0 = out1 = 0, busy = 1, residue frozen. ERR is sticky until rst.
- Not defined: no code_err port; illegal pairs are silently waited out, as stated in Behaviour.

Decomposition:
- Shared package mod_n_pkg:
  - state enum (IDLE, ACK, WAIT_SP, ERR);
  - function res_next(res, d, MODULUS) returning the reduced residue;
  - pair-state encoding constants (NULL, VALID0, VALID1, ILLEGAL).
- One natural sub-module: dr_sync_detect. It holds the SYNC_STAGES synchroniser plus the complete/spacer/illegal detector for a DIGIT_W-pair bus, and is reused by the other dual-rail receivers.

Test Plan:
- Reset then idle, default params, no input activity → out0 = out1 = 0, busy = 0, residue = 0; rst pulse mid-ACK → all outputs 0 asynchronously.
- MODULUS=3, DIGIT_W=1, bits 1,1,0 (value 6) with full four-phase handshakes → out0, out0, out1; residue 1, 0, 0.
- MODULUS=5, DIGIT_W=2, digits 2,3 (value 11) → residue 2 then 1; out0 both times. Then digit 1 (value 45) → residue 0, out1.
- Partial codeword: DIGIT_W=2, only pair 0 valid for 20 cycles → no capture, busy = 0. Complete pair 1 → capture within SYNC_STAGES+1 cycles.
- Held codeword: keep a complete codeword 10 cycles past its token → residue updates once only; the rail releases only after the spacer.
- With MOD_N_CODE_ERR_EN: drive in0[0] = in1[0] = 1 in IDLE → code_err = 1, out rails 0, residue frozen until rst. Without the macro, the same stimulus produces no token and no error.
